// File: rtl/fir_pkg.sv
// Shared constants and types for the inverse equalizer of the 8-tap, coefficient-16 FIR.
package fir_pkg;

  localparam int unsigned TAPS       = 8;
  localparam int unsigned COEF_SHIFT = 4;
  localparam int unsigned IN_W       = 32;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned PTR_W      = $clog2(TAPS);

  typedef enum logic {
    LOCKED = 1'b0,
    FAULT  = 1'b1
  } state_e;

  typedef logic signed [OUT_W-1:0] sample_t;
  typedef logic signed [IN_W-1:0]  word_t;
  typedef logic signed [IN_W:0]    wide_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam wide_t   WIDE_MAX   = {{(IN_W+1-OUT_W){1'b0}}, SAMPLE_MAX};
  localparam wide_t   WIDE_MIN   = {{(IN_W+1-OUT_W){1'b1}}, SAMPLE_MIN};

endpackage

// File: rtl/fir_inv_history.sv
// TAPS-deep circular buffer of reconstructed samples; the read port always shows the oldest entry.
module fir_inv_history
  import fir_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    we_i,
  input  logic signed [OUT_W-1:0] wdata_i,
  output logic signed [OUT_W-1:0] oldest_c_o
);

  sample_t            mem_q [TAPS];
  logic [PTR_W-1:0]   ptr_q;

  // TAPS is a power of two, so the pointer wraps by natural overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        mem_q[i] <= '0;
      end
      ptr_q <= '0;
    end else if (we_i) begin
      mem_q[ptr_q] <= wdata_i;
      ptr_q        <= ptr_q + PTR_W'(1);
    end
  end

  assign oldest_c_o = mem_q[ptr_q];

endmodule

// File: rtl/fir_inverse_equalizer.sv
// Rebuilds FIR input samples via x[n] = (y[n]-y[n-1])/16 + x[n-8]; flags non-FIR streams and overflow.
// Define FIR_INV_SATURATE_EN to clamp out-of-range samples instead of wrapping them.
module fir_inverse_equalizer
  import fir_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic signed [IN_W-1:0]  filter_in,
  input  logic                    err_clr,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    out_valid,
  output logic                    locked,
  output logic                    frac_err,
  output logic                    ovf_err
);

  state_e  state_q, state_d;
  word_t   y_prev_q, y_prev_d;
  sample_t data_q, data_d;
  logic    valid_q, valid_d;
  logic    frac_q, frac_d;
  logic    ovf_q, ovf_d;

  sample_t oldest_c;
  wide_t   diff_c;
  wide_t   quot_c;
  wide_t   sum_c;
  logic    rem_nz_c;
  logic    out_of_range_c;
  sample_t narrow_c;

  fir_inv_history u_history (
    .CLK        (CLK),
    .RST        (RST),
    .we_i       (ENABLE),
    .wdata_i    (data_d),
    .oldest_c_o (oldest_c)
  );

  // Datapath: difference, divide by the common coefficient, add back x[n-TAPS].
  always_comb begin
    diff_c         = $signed({filter_in[IN_W-1], filter_in}) - $signed({y_prev_q[IN_W-1], y_prev_q});
    quot_c         = diff_c >>> COEF_SHIFT;
    rem_nz_c       = |diff_c[COEF_SHIFT-1:0];
    sum_c          = quot_c + $signed({{(IN_W+1-OUT_W){oldest_c[OUT_W-1]}}, oldest_c});
    out_of_range_c = (sum_c > WIDE_MAX) || (sum_c < WIDE_MIN);
`ifdef FIR_INV_SATURATE_EN
    if (!out_of_range_c) begin
      narrow_c = sum_c[OUT_W-1:0];
    end else if (sum_c[IN_W]) begin
      narrow_c = SAMPLE_MIN;
    end else begin
      narrow_c = SAMPLE_MAX;
    end
`else
    narrow_c = sum_c[OUT_W-1:0];
`endif
  end

  // Next state: a new error on the same edge always overrides err_clr.
  always_comb begin
    state_d  = state_q;
    y_prev_d = y_prev_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    frac_d   = frac_q;
    ovf_d    = ovf_q;

    if (ENABLE) begin
      y_prev_d = filter_in;
      data_d   = narrow_c;
      valid_d  = 1'b1;
    end

    if (err_clr) begin
      state_d = LOCKED;
      frac_d  = 1'b0;
      ovf_d   = 1'b0;
    end

    if (ENABLE && rem_nz_c) begin
      state_d = FAULT;
      frac_d  = 1'b1;
    end

    if (ENABLE && out_of_range_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= LOCKED;
      y_prev_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      frac_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_prev_q <= y_prev_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      frac_q   <= frac_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign locked    = (state_q == LOCKED);
  assign frac_err  = frac_q;
  assign ovf_err   = ovf_q;

endmodule
